// File: rtl/exec_pkg.sv
// Shared constants for the execute/writeback stage: ARM condition codes,
// CPSR flag bit positions and the ALU no-op opcode.
package exec_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam logic [4:0] OP_NOP = 5'b11111;

endpackage

// File: rtl/cond_eval.sv
// ARM condition-field evaluator; purely combinational so branch logic can
// reuse it against any flag source.
module cond_eval
    import exec_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic z, c, n, v;

    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_writeback_stage.sv
// Single-entry writeback register behind the ALU; owns the CPSR and commits
// flags at accept. Define EXEC_WB_PERF_EN for retired/annulled counters.
module exec_writeback_stage
    import exec_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int PC_REG     = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            cond,
    input  logic                  set_flags,
    input  logic [4:0]            operation,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [3:0]            alu_flags,
    input  logic                  alu_writeback,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  pc_write,
`ifdef EXEC_WB_PERF_EN
    output logic [31:0]           retired_cnt,
    output logic [31:0]           annulled_cnt,
`endif
    output logic [3:0]            cpsr_flags
);

    logic                  out_valid_q;
    logic                  wb_en_q, wb_en_d;
    logic                  pc_write_q, pc_write_d;
    logic [REG_ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0]     wb_data_q;
    logic [3:0]            cpsr_q;
    logic                  pass, is_nop, accept, retire;

    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (cpsr_q),
        .pass  (pass)
    );

    assign is_nop     = (operation == OP_NOP);
    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign retire     = out_valid_q && out_ready;
    assign wb_en_d    = pass && alu_writeback && !is_nop;
    assign pc_write_d = wb_en_d && (dest_reg == REG_ADDR_W'(PC_REG));

    // Annulled entries are still captured so the downstream port sees every
    // instruction in order; only wb_en distinguishes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            wb_en_q     <= 1'b0;
            pc_write_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            cpsr_q      <= 4'b0000;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                wb_en_q     <= wb_en_d;
                pc_write_q  <= pc_write_d;
                wb_addr_q   <= dest_reg;
                wb_data_q   <= alu_result;
                if (pass && set_flags && !is_nop)
                    cpsr_q <= alu_flags;
            end else if (retire) begin
                out_valid_q <= 1'b0;
                wb_en_q     <= 1'b0;
                pc_write_q  <= 1'b0;
            end
        end
    end

`ifdef EXEC_WB_PERF_EN
    logic [31:0] retired_q, annulled_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q  <= '0;
            annulled_q <= '0;
        end else if (accept) begin
            if (pass) begin
                if (retired_q != 32'hFFFF_FFFF)
                    retired_q <= retired_q + 32'd1;
            end else begin
                if (annulled_q != 32'hFFFF_FFFF)
                    annulled_q <= annulled_q + 32'd1;
            end
        end
    end

    assign retired_cnt  = retired_q;
    assign annulled_cnt = annulled_q;
`endif

    assign out_valid  = out_valid_q;
    assign wb_en      = wb_en_q;
    assign pc_write   = pc_write_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign cpsr_flags = cpsr_q;

endmodule

// File: tb/tb_exec_writeback_stage.sv
// Directed bench for exec_writeback_stage: flags, condition codes, stalls,
// PC writes and annulment, with hand-computed expectations.
module tb_exec_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cond;
    logic        set_flags;
    logic [4:0]  operation;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        alu_writeback;
    logic [3:0]  dest_reg;
    logic        out_valid;
    logic        out_ready;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        pc_write;
    logic [3:0]  cpsr_flags;
`ifdef EXEC_WB_PERF_EN
    logic [31:0] retired_cnt, annulled_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    exec_writeback_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .cond          (cond),
        .set_flags     (set_flags),
        .operation     (operation),
        .alu_result    (alu_result),
        .alu_flags     (alu_flags),
        .alu_writeback (alu_writeback),
        .dest_reg      (dest_reg),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .pc_write      (pc_write),
`ifdef EXEC_WB_PERF_EN
        .retired_cnt   (retired_cnt),
        .annulled_cnt  (annulled_cnt),
`endif
        .cpsr_flags    (cpsr_flags)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic sf,
                         input logic [4:0] op, input logic [31:0] res,
                         input logic [3:0] fl, input logic wb, input logic [3:0] rd);
        in_valid      = v;
        cond          = c;
        set_flags     = sf;
        operation     = op;
        alu_result    = res;
        alu_flags     = fl;
        alu_writeback = wb;
        dest_reg      = rd;
    endtask

    task automatic idle();
        drive(1'b0, 4'hE, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic do_reset();
        idle();
        out_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        reset = 1'b1;
        drive(1'b1, 4'hE, 1'b1, 5'd1, 32'h55, 4'b1111, 1'b1, 4'd5);
        step();
        step();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (cpsr_flags !== 4'b0000) begin errors++; $display("FAIL reset_cpsr got %b want 0000", cpsr_flags); end
        vectors++; if ({wb_en, pc_write, wb_addr, wb_data} !== 38'd0) begin errors++; $display("FAIL reset_outputs got %b %b %h %h want all zero", wb_en, pc_write, wb_addr, wb_data); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        reset = 1'b0;
        drive(1'b1, 4'hE, 1'b0, 5'd1, 32'h55, 4'b1111, 1'b1, 4'd5);
        #2;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_accept_early got %b want 0", out_valid); end
        step();
        vectors++; if ({out_valid, wb_en, wb_addr, wb_data} !== {1'b1, 1'b1, 4'd5, 32'h55}) begin errors++; $display("FAIL first_accept got v=%b en=%b a=%h d=%h want v=1 en=1 a=5 d=55", out_valid, wb_en, wb_addr, wb_data); end
        idle();
        step();
        vectors++; if ({out_valid, wb_en, pc_write} !== 3'b000) begin errors++; $display("FAIL drain got %b want 000", {out_valid, wb_en, pc_write}); end
    endtask

    task automatic test_flags_eq();
        do_reset();
        drive(1'b1, 4'hE, 1'b1, 5'd2, 32'd0, 4'b0001, 1'b1, 4'd0);
        step();
        vectors++; if (cpsr_flags !== 4'b0001) begin errors++; $display("FAIL subs_cpsr got %b want 0001", cpsr_flags); end
        drive(1'b1, 4'h0, 1'b0, 5'd3, 32'h0000000A, 4'b0000, 1'b1, 4'd2);
        step();
        vectors++; if ({out_valid, wb_en, wb_addr, wb_data} !== {1'b1, 1'b1, 4'd2, 32'hA}) begin errors++; $display("FAIL addeq got v=%b en=%b a=%h d=%h want v=1 en=1 a=2 d=a", out_valid, wb_en, wb_addr, wb_data); end
        vectors++; if (cpsr_flags !== 4'b0001) begin errors++; $display("FAIL addeq_cpsr got %b want 0001", cpsr_flags); end
        idle();
        step();
    endtask

    task automatic test_annul();
        do_reset();
        drive(1'b1, 4'hE, 1'b1, 5'd4, 32'd0, 4'b0000, 1'b0, 4'd0);
        step();
        drive(1'b1, 4'h0, 1'b1, 5'd3, 32'h33, 4'b1111, 1'b1, 4'd3);
        step();
        vectors++; if ({out_valid, wb_en, pc_write, wb_addr} !== {1'b1, 1'b0, 1'b0, 4'd3}) begin errors++; $display("FAIL addeq_annul got v=%b en=%b pc=%b a=%h want v=1 en=0 pc=0 a=3", out_valid, wb_en, pc_write, wb_addr); end
        vectors++; if (cpsr_flags !== 4'b0000) begin errors++; $display("FAIL annul_cpsr got %b want 0000", cpsr_flags); end
`ifdef EXEC_WB_PERF_EN
        vectors++; if ({retired_cnt, annulled_cnt} !== {32'd1, 32'd1}) begin errors++; $display("FAIL perf_cnt got %0d/%0d want 1/1", retired_cnt, annulled_cnt); end
`endif
        idle();
        step();
    endtask

    task automatic test_cmp_lt();
        do_reset();
        drive(1'b1, 4'hE, 1'b1, 5'd5, 32'hFFFFFFFF, 4'b0100, 1'b0, 4'd7);
        step();
        vectors++; if ({out_valid, wb_en, cpsr_flags} !== {1'b1, 1'b0, 4'b0100}) begin errors++; $display("FAIL cmp got v=%b en=%b cpsr=%b want v=1 en=0 cpsr=0100", out_valid, wb_en, cpsr_flags); end
        drive(1'b1, 4'hB, 1'b0, 5'd6, 32'h7, 4'b0000, 1'b1, 4'd1);
        step();
        vectors++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 4'd1, 32'h7}) begin errors++; $display("FAIL movlt got en=%b a=%h d=%h want en=1 a=1 d=7", wb_en, wb_addr, wb_data); end
        idle();
        step();
    endtask

    task automatic test_back_to_back_stall();
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 4'hE, 1'b0, 5'd1, 32'hDEADBEEF, 4'b0000, 1'b1, 4'd4);
        step();
        drive(1'b1, 4'hE, 1'b1, 5'd1, 32'h66, 4'b1000, 1'b1, 4'd6);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({in_ready, out_valid, wb_en, wb_addr, wb_data, cpsr_flags} !== {1'b0, 1'b1, 1'b1, 4'd4, 32'hDEADBEEF, 4'b0000}) begin
                errors++;
                $display("FAIL stall_hold[%0d] got rdy=%b v=%b en=%b a=%h d=%h cpsr=%b want rdy=0 v=1 en=1 a=4 d=deadbeef cpsr=0000", i, in_ready, out_valid, wb_en, wb_addr, wb_data, cpsr_flags);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
        step();
        vectors++; if ({out_valid, wb_addr, wb_data, cpsr_flags} !== {1'b1, 4'd6, 32'h66, 4'b1000}) begin errors++; $display("FAIL retire_accept got v=%b a=%h d=%h cpsr=%b want v=1 a=6 d=66 cpsr=1000", out_valid, wb_addr, wb_data, cpsr_flags); end
        idle();
        step();
    endtask

    task automatic test_pc_nop();
        do_reset();
        drive(1'b1, 4'hE, 1'b0, 5'd1, 32'h00000100, 4'b0000, 1'b1, 4'd15);
        step();
        vectors++; if ({pc_write, wb_en, wb_addr, wb_data} !== {1'b1, 1'b1, 4'd15, 32'h100}) begin errors++; $display("FAIL mov_pc got pc=%b en=%b a=%h d=%h want pc=1 en=1 a=f d=100", pc_write, wb_en, wb_addr, wb_data); end
        drive(1'b1, 4'hF, 1'b1, 5'b11111, 32'h200, 4'b1111, 1'b1, 4'd15);
        step();
        vectors++; if ({out_valid, wb_en, pc_write, cpsr_flags} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin errors++; $display("FAIL nv_nop got v=%b en=%b pc=%b cpsr=%b want v=1 en=0 pc=0 cpsr=0000", out_valid, wb_en, pc_write, cpsr_flags); end
        drive(1'b1, 4'hE, 1'b1, 5'b11111, 32'h300, 4'b1111, 1'b1, 4'd15);
        step();
        vectors++; if ({wb_en, pc_write, cpsr_flags} !== {1'b0, 1'b0, 4'b0000}) begin errors++; $display("FAIL al_nop got en=%b pc=%b cpsr=%b want en=0 pc=0 cpsr=0000", wb_en, pc_write, cpsr_flags); end
        drive(1'b1, 4'hE, 1'b0, 5'd1, 32'h44, 4'b0000, 1'b1, 4'd14);
        step();
        vectors++; if ({wb_en, pc_write} !== 2'b10) begin errors++; $display("FAIL r14_no_pc got en=%b pc=%b want en=1 pc=0", wb_en, pc_write); end
        idle();
        step();
    endtask

    // flags (V N C Z), condition, expected pass
    logic [8:0] cond_tbl [0:11] = '{
        {4'b0010, 4'h8, 1'b1}, {4'b0011, 4'h8, 1'b0}, {4'b0011, 4'h9, 1'b1},
        {4'b1000, 4'hA, 1'b0}, {4'b1000, 4'hC, 1'b0}, {4'b1000, 4'hD, 1'b1},
        {4'b1100, 4'hA, 1'b1}, {4'b1100, 4'hC, 1'b1}, {4'b1000, 4'h6, 1'b1},
        {4'b1000, 4'h7, 1'b0}, {4'b0000, 4'h5, 1'b1}, {4'b0000, 4'h2, 1'b0}
    };

    task automatic test_cond_codes();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            logic [8:0] e;
            e = cond_tbl[i];
            drive(1'b1, 4'hE, 1'b1, 5'd5, 32'd0, e[8:5], 1'b0, 4'd0);
            step();
            drive(1'b1, e[4:1], 1'b0, 5'd1, 32'(i), 4'b0000, 1'b1, 4'd8);
            step();
            vectors++;
            if (wb_en !== e[0]) begin
                errors++;
                $display("FAIL cond[%0d] flags=%b cond=%h got en=%b want %b", i, e[8:5], e[4:1], wb_en, e[0]);
            end
        end
        idle();
        step();
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        idle();
        test_reset();
        test_flags_eq();
        test_annul();
        test_cmp_lt();
        test_back_to_back_stall();
        test_pc_nop();
        test_cond_codes();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
